// File: rtl/turf_fragment_reassembler_pkg.sv
// turf_fragment_reassembler_pkg
//   Shared definitions for the TURF fragment generator/reassembler pair:
//   tag magic constants, the 8-byte fragment tag layout and the reassembler
//   state encoding.
//   Tag layout (64 bits): magic[63:48], pad[47:42], frag[41:32],
//   addr[31:20], len[19:0].
package turf_fragment_reassembler_pkg;

  localparam logic [15:0] TAG_CONSTANT_0 = 16'hDA7A;
  localparam logic [5:0]  TAG_CONSTANT_1 = 6'h00;

  // Field order matches the wire layout so a plain cast decodes a tag beat.
  typedef struct packed {
    logic [15:0] magic;
    logic [5:0]  pad;
    logic [9:0]  frag;
    logic [11:0] addr;
    logic [19:0] len;
  } tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_CTRL,
    ST_STREAM,
    ST_DROP,
    ST_ABORT
  } state_t;

  // The error counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/turf_fragment_reassembler.sv
// turf_fragment_reassembler
//   Receive-side partner of the TURF UDP fragment generator. Validates each
//   fragment's tag and sequence number, then stitches fragment payloads into
//   one 64-bit event stream preceded by a single {addr, len} control word.
//   Bad or out-of-order fragments are dropped and counted; a bad fragment in
//   the middle of an event truncates the event with an abort beat.
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   s_hdr_*               UDP header stream, {ip, port, udp_len}
//   s_payload_*           UDP payload stream, first beat of each fragment is the tag
//   m_ctrl_*              per-event control word {addr[11:0], len[19:0]}
//   m_data_*              reassembled event data; tuser marks an abort beat
//   err_count_o           saturating count of dropped fragments
//   event_count_o         wrapping count of completed events
module turf_fragment_reassembler
  import turf_fragment_reassembler_pkg::*;
#(
  parameter logic [15:0] CONSTANT_0 = TAG_CONSTANT_0,
  parameter logic [5:0]  CONSTANT_1 = TAG_CONSTANT_1,
  parameter string       DEBUG      = "FALSE"
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] s_hdr_tdata,
  input  logic        s_hdr_tvalid,
  output logic        s_hdr_tready,
  input  logic [63:0] s_payload_tdata,
  input  logic [7:0]  s_payload_tkeep,
  input  logic        s_payload_tlast,
  input  logic        s_payload_tvalid,
  output logic        s_payload_tready,
  output logic [31:0] m_ctrl_tdata,
  output logic        m_ctrl_tvalid,
  input  logic        m_ctrl_tready,
  output logic [63:0] m_data_tdata,
  output logic [7:0]  m_data_tkeep,
  output logic        m_data_tlast,
  output logic        m_data_tuser,
  output logic        m_data_tvalid,
  input  logic        m_data_tready,
  output logic [15:0] err_count_o,
  output logic [15:0] event_count_o
);

  state_t      state, next_state;
  logic [15:0] udp_len;
  logic        mid_event;
  logic [9:0]  expected;
  logic [11:0] ev_addr;
  logic [19:0] ev_len;
  logic [19:0] remaining;
  logic        tag_last;
  logic [15:0] err_count;
  logic [15:0] event_count;

  tag_t        tag;
  logic [19:0] payload_bytes;
  logic [19:0] rem_check;
  logic        is_final;
  logic        tag_ok;
  logic        cont_match;
  logic        last_beat;
  logic        err_inc;
  logic        hdr_ready_c, pay_ready_c, ctrl_valid_c, data_valid_c;

  // Only udp_len is needed from the header; ip and port are ignored.
  logic unused_hdr;
  assign unused_hdr = ^s_hdr_tdata[63:16];

  assign tag = tag_t'(s_payload_tdata);

  // A fragment counts as final when its data bytes (udp_len minus UDP
  // header and tag) cover what is still owed to the event. Only the final
  // fragment may have a length that is not a whole number of beats.
  assign payload_bytes = 20'(udp_len) - 20'd16;
  assign rem_check     = mid_event ? remaining : tag.len;
  assign is_final      = payload_bytes >= rem_check;
  assign tag_ok        = (tag.magic == CONSTANT_0) && (tag.pad == CONSTANT_1) &&
                         (udp_len >= 16'd16) && (is_final || udp_len[2:0] == 3'd0) &&
                         (tag.frag == expected);
  assign cont_match    = (tag.addr == ev_addr) && (tag.len == ev_len);
  assign last_beat     = remaining <= 20'd8;

  // All handshake outputs are held low while reset is asserted.
  assign s_hdr_tready     = hdr_ready_c & ~areset;
  assign s_payload_tready = pay_ready_c & ~areset;
  assign m_ctrl_tvalid    = ctrl_valid_c & ~areset;
  assign m_data_tvalid    = data_valid_c & ~areset;
  assign m_ctrl_tdata     = {ev_addr, ev_len};
  assign err_count_o      = err_count;
  assign event_count_o    = event_count;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and output decode. In STREAM the payload is a straight
  // combinational pass-through, so upstream ready is downstream ready.
  always_comb begin
    next_state   = state;
    hdr_ready_c  = 1'b0;
    pay_ready_c  = 1'b0;
    ctrl_valid_c = 1'b0;
    data_valid_c = 1'b0;
    m_data_tdata = s_payload_tdata;
    m_data_tkeep = s_payload_tkeep;
    m_data_tlast = 1'b0;
    m_data_tuser = 1'b0;
    err_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        hdr_ready_c = 1'b1;
        if (s_hdr_tvalid) next_state = ST_TAG;
      end
      ST_TAG: begin
        pay_ready_c = 1'b1;
        if (s_payload_tvalid) begin
          if (!mid_event) begin
            if (tag_ok && tag.len != 20'd0) begin
              next_state = ST_CTRL;
            end else begin
              err_inc    = 1'b1;
              next_state = s_payload_tlast ? ST_IDLE : ST_DROP;
            end
          end else if (tag_ok && cont_match) begin
            next_state = ST_STREAM;
          end else begin
            err_inc    = 1'b1;
            next_state = ST_ABORT;
          end
        end
      end
      ST_CTRL: begin
        ctrl_valid_c = 1'b1;
        if (m_ctrl_tready) next_state = ST_STREAM;
      end
      ST_STREAM: begin
        data_valid_c = s_payload_tvalid;
        pay_ready_c  = m_data_tready;
        m_data_tlast = last_beat;
        if (s_payload_tvalid && m_data_tready) begin
          if (last_beat) begin
            // Beats left over after the event's last byte are junk.
            if (!s_payload_tlast) begin
              err_inc    = 1'b1;
              next_state = ST_DROP;
            end else begin
              next_state = ST_IDLE;
            end
          end else if (s_payload_tlast) begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        pay_ready_c = 1'b1;
        if (s_payload_tvalid && s_payload_tlast) next_state = ST_IDLE;
      end
      ST_ABORT: begin
        data_valid_c = 1'b1;
        m_data_tdata = 64'd0;
        m_data_tkeep = 8'h00;
        m_data_tlast = 1'b1;
        m_data_tuser = 1'b1;
        if (m_data_tready) next_state = tag_last ? ST_IDLE : ST_DROP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Event bookkeeping: latched header length, event identity, bytes still
  // owed, next fragment number, and the two counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      udp_len     <= 16'd0;
      mid_event   <= 1'b0;
      expected    <= 10'd0;
      ev_addr     <= 12'd0;
      ev_len      <= 20'd0;
      remaining   <= 20'd0;
      tag_last    <= 1'b0;
      err_count   <= 16'd0;
      event_count <= 16'd0;
    end else begin
      if (err_inc) err_count <= sat_inc16(err_count);
      case (state)
        ST_IDLE: begin
          if (s_hdr_tvalid) udp_len <= s_hdr_tdata[15:0];
        end
        ST_TAG: begin
          if (s_payload_tvalid) begin
            tag_last <= s_payload_tlast;
            if (!mid_event && next_state == ST_CTRL) begin
              ev_addr   <= tag.addr;
              ev_len    <= tag.len;
              remaining <= tag.len;
              expected  <= 10'd1;
              mid_event <= 1'b1;
            end else if (mid_event && next_state == ST_STREAM) begin
              expected <= expected + 10'd1;
            end
          end
        end
        ST_STREAM: begin
          if (s_payload_tvalid && m_data_tready) begin
            remaining <= remaining - (last_beat ? remaining : 20'd8);
            if (last_beat) begin
              event_count <= event_count + 16'd1;
              expected    <= 10'd0;
              mid_event   <= 1'b0;
            end
          end
        end
        ST_ABORT: begin
          if (m_data_tready) begin
            expected  <= 10'd0;
            mid_event <= 1'b0;
            remaining <= 20'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Debug probes for an on-chip logic analyser, only built on request.
  generate
    if (DEBUG == "TRUE") begin : g_debug
      (* mark_debug = "true" *) logic [2:0]  dbg_state;
      (* mark_debug = "true" *) logic [19:0] dbg_remaining;
      (* mark_debug = "true" *) logic [5:0]  dbg_handshakes;
      assign dbg_state      = state;
      assign dbg_remaining  = remaining;
      assign dbg_handshakes = {s_hdr_tvalid & s_hdr_tready,
                               s_payload_tvalid & s_payload_tready,
                               m_ctrl_tvalid & m_ctrl_tready,
                               m_data_tvalid & m_data_tready,
                               m_data_tlast, m_data_tuser};
    end
  endgenerate

endmodule

// File: tb/tb_turf_fragment_reassembler.sv
// tb_turf_fragment_reassembler
//   Directed bench for turf_fragment_reassembler. A fragment-level model
//   predicts the control words, data beats and counters; a monitor compares
//   every accepted output beat against those predictions.
module tb_turf_fragment_reassembler;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] s_hdr_tdata;
  logic        s_hdr_tvalid;
  logic        s_hdr_tready;
  logic [63:0] s_payload_tdata;
  logic [7:0]  s_payload_tkeep;
  logic        s_payload_tlast;
  logic        s_payload_tvalid;
  logic        s_payload_tready;
  logic [31:0] m_ctrl_tdata;
  logic        m_ctrl_tvalid;
  logic        m_ctrl_tready;
  logic [63:0] m_data_tdata;
  logic [7:0]  m_data_tkeep;
  logic        m_data_tlast;
  logic        m_data_tuser;
  logic        m_data_tvalid;
  logic        m_data_tready;
  logic [15:0] err_count_o;
  logic [15:0] event_count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ctrl_q[$];
  beat_t       exp_data_q[$];

  // Fragment-level model state
  bit          m_open;
  int          m_next_frag;
  int          m_left;
  logic [11:0] m_addr;
  logic [19:0] m_len;
  int          m_err;
  int          m_events;

  bit          toggle_ready = 1'b0;
  int          data_seen = 0;
  logic [31:0] last_ctrl;
  beat_t       last_beat;

  always #5 aclk = ~aclk;

  turf_fragment_reassembler dut (
    .aclk             (aclk),
    .areset           (areset),
    .s_hdr_tdata      (s_hdr_tdata),
    .s_hdr_tvalid     (s_hdr_tvalid),
    .s_hdr_tready     (s_hdr_tready),
    .s_payload_tdata  (s_payload_tdata),
    .s_payload_tkeep  (s_payload_tkeep),
    .s_payload_tlast  (s_payload_tlast),
    .s_payload_tvalid (s_payload_tvalid),
    .s_payload_tready (s_payload_tready),
    .m_ctrl_tdata     (m_ctrl_tdata),
    .m_ctrl_tvalid    (m_ctrl_tvalid),
    .m_ctrl_tready    (m_ctrl_tready),
    .m_data_tdata     (m_data_tdata),
    .m_data_tkeep     (m_data_tkeep),
    .m_data_tlast     (m_data_tlast),
    .m_data_tuser     (m_data_tuser),
    .m_data_tvalid    (m_data_tvalid),
    .m_data_tready    (m_data_tready),
    .err_count_o      (err_count_o),
    .event_count_o    (event_count_o)
  );

  function automatic logic [63:0] make_tag(input logic [15:0] magic, input logic [9:0] frag,
                                           input logic [11:0] addr, input logic [19:0] len);
    return {magic, 6'h00, frag, addr, len};
  endfunction

  function automatic logic [63:0] beat_data(input logic [31:0] seed, input int i);
    return {seed, 32'(i) ^ 32'hA5A50000};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Predicts what one fragment must produce, from the tag rules alone.
  task automatic model_fragment(input logic [15:0] udp_len, input logic [63:0] tag, input int nbeats,
                                input logic [7:0] last_keep, input logic [31:0] seed);
    int          frag;
    logic [11:0] addr;
    logic [19:0] len;
    int          left_before;
    bit          final_frag;
    bit          good;
    beat_t       b;
    frag        = int'(tag[41:32]);
    addr        = tag[31:20];
    len         = tag[19:0];
    left_before = m_open ? m_left : int'(len);
    final_frag  = (int'(udp_len) - 16) >= left_before;
    good        = (tag[63:48] == 16'hDA7A) && (tag[47:42] == 6'h00) && (udp_len >= 16'd16) &&
                  (final_frag || udp_len[2:0] == 3'd0);
    if (!m_open) begin
      if (!good || frag != 0 || len == 20'd0) begin
        m_err++;
        return;
      end
      exp_ctrl_q.push_back({addr, len});
      m_open = 1; m_next_frag = 1; m_left = int'(len); m_addr = addr; m_len = len;
    end else begin
      if (!good || frag != m_next_frag || addr != m_addr || len != m_len) begin
        m_err++;
        b = '{data: 64'd0, keep: 8'h00, last: 1'b1, user: 1'b1};
        exp_data_q.push_back(b);
        m_open = 0; m_left = 0;
        return;
      end
      m_next_frag++;
    end
    for (int i = 0; i < nbeats; i++) begin
      b.data = beat_data(seed, i);
      b.keep = (i == nbeats - 1) ? last_keep : 8'hFF;
      b.last = (m_left <= 8);
      b.user = 1'b0;
      exp_data_q.push_back(b);
      m_left -= (m_left < 8) ? m_left : 8;
      if (b.last) begin
        m_events++;
        m_open = 0;
        if (i != nbeats - 1) m_err++;
        break;
      end
    end
  endtask

  // Called at a falling edge with inputs already presented; returns at the
  // falling edge after the handshake.
  task automatic wait_handshake(input bit is_payload);
    int n = 0;
    forever begin
      #1;
      if (is_payload ? s_payload_tready : s_hdr_tready) begin
        @(posedge aclk);
        break;
      end
      @(negedge aclk);
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("[TB] FAIL handshake_timeout: payload=%0d ready stayed 0, required 1", is_payload);
        break;
      end
    end
    @(negedge aclk);
  endtask

  task automatic drive_hdr(input logic [15:0] udp_len);
    s_hdr_tdata  = {32'hC0A80001, 16'd4000, udp_len};
    s_hdr_tvalid = 1'b1;
    wait_handshake(1'b0);
    s_hdr_tvalid = 1'b0;
  endtask

  task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
    s_payload_tdata  = data;
    s_payload_tkeep  = keep;
    s_payload_tlast  = last;
    s_payload_tvalid = 1'b1;
    wait_handshake(1'b1);
  endtask

  // One fragment: header, tag beat, nbeats data beats. send_last=0 leaves
  // the fragment unterminated.
  task automatic applyStimulus(input logic [15:0] udp_len, input logic [63:0] tag, input int nbeats,
                               input logic [7:0] last_keep, input logic [31:0] seed, input bit send_last);
    model_fragment(udp_len, tag, nbeats, last_keep, seed);
    drive_hdr(udp_len);
    drive_beat(tag, 8'hFF, send_last && nbeats == 0);
    for (int i = 0; i < nbeats; i++)
      drive_beat(beat_data(seed, i), (i == nbeats - 1) ? last_keep : 8'hFF, send_last && (i == nbeats - 1));
    s_payload_tvalid = 1'b0;
    s_payload_tlast  = 1'b0;
  endtask

  task automatic end_test(input string name);
    repeat (4) @(negedge aclk);
    checks++;
    if (exp_ctrl_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: ctrl pending %0d data pending %0d, expected 0 and 0",
               name, exp_ctrl_q.size(), exp_data_q.size());
    end
    exp_ctrl_q.delete();
    exp_data_q.delete();
    checkOutput({name, "_err_count"}, 64'(err_count_o), 64'(m_err));
    checkOutput({name, "_event_count"}, 64'(event_count_o), 64'(m_events));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(negedge aclk);
    #1;
    checkOutput("rst_ctrl_tvalid", 64'(m_ctrl_tvalid), 64'd0);
    checkOutput("rst_data_tvalid", 64'(m_data_tvalid), 64'd0);
    checkOutput("rst_payload_tready", 64'(s_payload_tready), 64'd0);
    checkOutput("rst_hdr_tready", 64'(s_hdr_tready), 64'd0);
    checkOutput("rst_err_count", 64'(err_count_o), 64'd0);
    checkOutput("rst_event_count", 64'(event_count_o), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    m_open = 0; m_next_frag = 0; m_left = 0; m_err = 0; m_events = 0;
    exp_ctrl_q.delete();
    exp_data_q.delete();
    @(negedge aclk);
    checkOutput("rst_hdr_tready_after", 64'(s_hdr_tready), 64'd1);
  endtask

  // Downstream ready generator: always ready, or alternating each cycle.
  initial begin
    m_data_tready = 1'b1;
    m_ctrl_tready = 1'b1;
    forever begin
      @(negedge aclk);
      m_data_tready = toggle_ready ? ~m_data_tready : 1'b1;
      m_ctrl_tready = toggle_ready ? m_data_tready : 1'b1;
    end
  end

  // Compare process: every accepted ctrl word and data beat is checked
  // against the next model prediction.
  initial begin
    beat_t b;
    forever begin
      @(negedge aclk);
      #2;
      if (!areset) begin
        if (m_ctrl_tvalid && m_ctrl_tready) begin
          last_ctrl = m_ctrl_tdata;
          if (exp_ctrl_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL ctrl_unexpected: got %h, expected no ctrl word", m_ctrl_tdata);
          end else begin
            checkOutput("ctrl_tdata", 64'(m_ctrl_tdata), 64'(exp_ctrl_q.pop_front()));
          end
        end
        if (m_data_tvalid && m_data_tready) begin
          data_seen++;
          last_beat = '{data: m_data_tdata, keep: m_data_tkeep, last: m_data_tlast, user: m_data_tuser};
          if (exp_data_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL data_unexpected: got %h, expected no data beat", m_data_tdata);
          end else begin
            b = exp_data_q.pop_front();
            checkOutput("data_tdata", m_data_tdata, b.data);
            checkOutput("data_tkeep", 64'(m_data_tkeep), 64'(b.keep));
            checkOutput("data_tlast", 64'(m_data_tlast), 64'(b.last));
            checkOutput("data_tuser", 64'(m_data_tuser), 64'(b.user));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen0;
    areset           = 1'b1;
    s_hdr_tdata      = 64'd0;
    s_hdr_tvalid     = 1'b0;
    s_payload_tdata  = 64'd0;
    s_payload_tkeep  = 8'h00;
    s_payload_tlast  = 1'b0;
    s_payload_tvalid = 1'b0;
    @(negedge aclk);
    do_reset();

    // 1) three-fragment event, 200 bytes in 9/9/7 beats
    $display("[TB] test 1: three-fragment event");
    seen0 = data_seen;
    applyStimulus(16'd88, make_tag(16'hDA7A, 10'd0, 12'h123, 20'd200), 9, 8'hFF, 32'h11110000, 1'b1);
    applyStimulus(16'd88, make_tag(16'hDA7A, 10'd1, 12'h123, 20'd200), 9, 8'hFF, 32'h11110001, 1'b1);
    applyStimulus(16'd72, make_tag(16'hDA7A, 10'd2, 12'h123, 20'd200), 7, 8'hFF, 32'h11110002, 1'b1);
    end_test("t1");
    checkOutput("t1_ctrl_word", 64'(last_ctrl), 64'h123000C8);
    checkOutput("t1_beats", 64'(data_seen - seen0), 64'd25);
    checkOutput("t1_last_tlast", 64'(last_beat.last), 64'd1);
    checkOutput("t1_event_count_lit", 64'(event_count_o), 64'd1);

    // 2) bad magic on a lone fragment 0, then a good event
    $display("[TB] test 2: bad tag magic");
    seen0 = data_seen;
    applyStimulus(16'd32, make_tag(16'hBEEF, 10'd0, 12'h055, 20'd16), 2, 8'hFF, 32'h22220000, 1'b1);
    checkOutput("t2_bad_no_output", 64'(data_seen - seen0), 64'd0);
    checkOutput("t2_err_count_lit", 64'(err_count_o), 64'd1);
    applyStimulus(16'd32, make_tag(16'hDA7A, 10'd0, 12'h055, 20'd16), 2, 8'hFF, 32'h22220001, 1'b1);
    end_test("t2");

    // 3) fragment 1 skipped: abort beat, rest of fragment 2 drained
    $display("[TB] test 3: skipped fragment");
    applyStimulus(16'd48, make_tag(16'hDA7A, 10'd0, 12'h3C0, 20'd96), 4, 8'hFF, 32'h33330000, 1'b1);
    applyStimulus(16'd48, make_tag(16'hDA7A, 10'd2, 12'h3C0, 20'd96), 4, 8'hFF, 32'h33330002, 1'b1);
    end_test("t3");
    checkOutput("t3_abort_user", 64'(last_beat.user), 64'd1);
    checkOutput("t3_abort_keep", 64'(last_beat.keep), 64'h00);
    checkOutput("t3_abort_last", 64'(last_beat.last), 64'd1);
    checkOutput("t3_err_count_lit", 64'(err_count_o), 64'd2);

    // 4) 20-byte event, partial final beat, downstream ready toggling
    $display("[TB] test 4: backpressure and partial keep");
    toggle_ready = 1'b1;
    applyStimulus(16'd36, make_tag(16'hDA7A, 10'd0, 12'h7FF, 20'd20), 3, 8'h0F, 32'h44440000, 1'b1);
    end_test("t4");
    toggle_ready = 1'b0;
    checkOutput("t4_last_keep", 64'(last_beat.keep), 64'h0F);

    // 5) fragment 1 with no event open
    $display("[TB] test 5: orphan fragment");
    seen0 = data_seen;
    applyStimulus(16'd40, make_tag(16'hDA7A, 10'd1, 12'h010, 20'd40), 3, 8'hFF, 32'h55550000, 1'b1);
    end_test("t5");
    checkOutput("t5_no_output", 64'(data_seen - seen0), 64'd0);

    // 7) beats past the end of the event inside one fragment
    $display("[TB] test 7: overrun beats");
    applyStimulus(16'd32, make_tag(16'hDA7A, 10'd0, 12'h0AA, 20'd8), 2, 8'hFF, 32'h77770000, 1'b1);
    end_test("t7");

    // 6) reset in the middle of fragment 1, then a fresh event
    $display("[TB] test 6: reset mid-stream");
    applyStimulus(16'd48, make_tag(16'hDA7A, 10'd0, 12'h200, 20'd64), 4, 8'hFF, 32'h66660000, 1'b1);
    applyStimulus(16'd48, make_tag(16'hDA7A, 10'd1, 12'h200, 20'd64), 2, 8'hFF, 32'h66660001, 1'b0);
    end_test("t6_pre");
    do_reset();
    applyStimulus(16'd40, make_tag(16'hDA7A, 10'd0, 12'hABC, 20'd24), 3, 8'hFF, 32'h66660010, 1'b1);
    end_test("t6_post");
    checkOutput("t6_ctrl_word", 64'(last_ctrl), 64'hABC00018);
    checkOutput("t6_event_count_lit", 64'(event_count_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
